// File: rtl/alu_arbiter_pkg.sv
// Shared ALU-arbiter definitions: ALUOp encodings, FSM states and the op-legality check.
package alu_pkg;

    localparam logic [4:0] ALUOp_nop   = 5'b00000;
    localparam logic [4:0] ALUOp_lui   = 5'b00001;
    localparam logic [4:0] ALUOp_auipc = 5'b00010;
    localparam logic [4:0] ALUOp_add   = 5'b00011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [4:0] op);
        return (op == ALUOp_lui) || (op == ALUOp_auipc) || (op == ALUOp_add);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester/response bundle of the ALU arbiter: two request ports and one response channel.
interface alu_arbiter_if #(
    parameter int DW   = 32,
    parameter int OPW  = 5,
    parameter int TAGW = 4
) ();
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [DW-1:0]   req0_a;
    logic [DW-1:0]   req0_b;
    logic [OPW-1:0]  req0_op;
    logic [TAGW-1:0] req0_tag;
    logic [DW-1:0]   req1_a;
    logic [DW-1:0]   req1_b;
    logic [OPW-1:0]  req1_op;
    logic [TAGW-1:0] req1_tag;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic            rsp_zero;
    logic            rsp_err;
    logic            rsp_id;
    logic [TAGW-1:0] rsp_tag;

    modport master (
        output req_valid, req0_a, req0_b, req0_op, req0_tag,
               req1_a, req1_b, req1_op, req1_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, rsp_id, rsp_tag
    );

    modport slave (
        input  req_valid, req0_a, req0_b, req0_op, req0_tag,
               req1_a, req1_b, req1_op, req1_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, rsp_id, rsp_tag
    );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way grant logic: a lone request always wins; a tie goes to ptr when rr_en, else port 0.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       rr_en,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = (rr_en && ptr) ? 2'b10 : 2'b01;
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: grant in IDLE, drive the ALU in EXEC,
// hold the captured result in RESP until the consumer takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DW   = 32,
    parameter int OPW  = 5,
    parameter int TAGW = 4,
    parameter int RR   = 1
) (
    input  logic            clk,
    input  logic            rstn,
    alu_arbiter_if.slave    bus,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [OPW-1:0]  alu_op,
    input  logic [DW-1:0]   alu_c,
    input  logic [7:0]      alu_zero
);
    state_t          state;
    logic            rr_ptr;
    logic            id_q;
    logic            err_q;
    logic [TAGW-1:0] tag_q;
    logic [1:0]      gnt;
    logic            gid;
    logic            take;
    logic            legal;
    logic [DW-1:0]   sel_a;
    logic [DW-1:0]   sel_b;
    logic [OPW-1:0]  sel_op;
    logic [TAGW-1:0] sel_tag;
    logic            unused_zero_hi;

    assign unused_zero_hi = ^alu_zero[7:1];

    rr_arb2 u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .rr_en (RR != 0),
        .gnt   (gnt)
    );

    assign bus.req_ready = (state == IDLE) ? gnt : 2'b00;
    assign take    = |(bus.req_valid & bus.req_ready);
    assign gid     = gnt[1];
    assign sel_a   = gid ? bus.req1_a   : bus.req0_a;
    assign sel_b   = gid ? bus.req1_b   : bus.req0_b;
    assign sel_op  = gid ? bus.req1_op  : bus.req0_op;
    assign sel_tag = gid ? bus.req1_tag : bus.req0_tag;
    assign legal   = is_legal_op(sel_op);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            rr_ptr        <= 1'b0;
            id_q          <= 1'b0;
            err_q         <= 1'b0;
            tag_q         <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_op        <= OPW'(ALUOp_nop);
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_zero  <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_tag   <= '0;
        end else begin
            case (state)
                IDLE: if (take) begin
                    alu_a  <= sel_a;
                    alu_b  <= sel_b;
                    // an illegal op never reaches the ALU; the error is reported from err_q
                    alu_op <= legal ? sel_op : OPW'(ALUOp_nop);
                    err_q  <= !legal;
                    tag_q  <= sel_tag;
                    id_q   <= gid;
                    if (RR != 0)
                        rr_ptr <= ~gid;
                    state  <= EXEC;
                end
                EXEC: begin
                    bus.rsp_data  <= err_q ? '0 : alu_c;
                    bus.rsp_zero  <= err_q | alu_zero[0];
                    bus.rsp_err   <= err_q;
                    bus.rsp_id    <= id_q;
                    bus.rsp_tag   <= tag_q;
                    bus.rsp_valid <= 1'b1;
                    alu_op        <= OPW'(ALUOp_nop);
                    state         <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random streams on a round-robin and a
// fixed-priority instance, checked against a transaction-level model.
module tb_alu_arbiter;
    localparam int DW   = 32;
    localparam int OPW  = 5;
    localparam int TAGW = 4;

    typedef struct packed {
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        logic [OPW-1:0]  op;
        logic [TAGW-1:0] tag;
    } req_t;

    typedef struct packed {
        logic            vld;
        logic [DW-1:0]   data;
        logic            zero;
        logic            err;
        logic            id;
        logic [TAGW-1:0] tag;
    } rsp_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // index 0: fixed-priority instance, index 1: round-robin instance
    req_t            rq[2][2];
    logic [1:0]      valid[2];
    logic            rsp_rdy[2];
    logic [1:0]      ready[2];
    rsp_t            rsp[2];
    logic [DW-1:0]   alu_a[2];
    logic [DW-1:0]   alu_b[2];
    logic [DW-1:0]   alu_c[2];
    logic [OPW-1:0]  alu_op[2];
    logic [7:0]      alu_zero[2];
    bit              mptr[2];
    int              total = 0;
    int              bad = 0;

    // external ALU: lui passes B, auipc/add sum, nop yields junk the arbiter must never forward
    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [OPW-1:0] op);
        case (op)
            5'b00001:          return b;
            5'b00010, 5'b00011: return a + b;
            default:           return a ^ b ^ 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic rsp_t model(input req_t r, input logic id);
        rsp_t e;
        logic ok;
        ok     = (r.op == 5'd1) || (r.op == 5'd2) || (r.op == 5'd3);
        e.vld  = 1'b1;
        e.data = ok ? alu_fn(r.a, r.b, r.op) : '0;
        e.zero = (e.data == '0);
        e.err  = !ok;
        e.id   = id;
        e.tag  = r.tag;
        return e;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.a   = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
        r.b   = ($urandom_range(0, 7) == 0) ? 32'd1 : $urandom;
        r.op  = 5'($urandom_range(0, 4));
        r.tag = 4'($urandom);
        return r;
    endfunction

    alu_arbiter_if #(.DW(DW), .OPW(OPW), .TAGW(TAGW)) bus_fp ();
    alu_arbiter_if #(.DW(DW), .OPW(OPW), .TAGW(TAGW)) bus_rr ();

    assign bus_fp.req_valid = valid[0];
    assign bus_fp.req0_a    = rq[0][0].a;
    assign bus_fp.req0_b    = rq[0][0].b;
    assign bus_fp.req0_op   = rq[0][0].op;
    assign bus_fp.req0_tag  = rq[0][0].tag;
    assign bus_fp.req1_a    = rq[0][1].a;
    assign bus_fp.req1_b    = rq[0][1].b;
    assign bus_fp.req1_op   = rq[0][1].op;
    assign bus_fp.req1_tag  = rq[0][1].tag;
    assign bus_fp.rsp_ready = rsp_rdy[0];
    assign ready[0] = bus_fp.req_ready;
    assign rsp[0]   = {bus_fp.rsp_valid, bus_fp.rsp_data, bus_fp.rsp_zero,
                       bus_fp.rsp_err, bus_fp.rsp_id, bus_fp.rsp_tag};

    assign bus_rr.req_valid = valid[1];
    assign bus_rr.req0_a    = rq[1][0].a;
    assign bus_rr.req0_b    = rq[1][0].b;
    assign bus_rr.req0_op   = rq[1][0].op;
    assign bus_rr.req0_tag  = rq[1][0].tag;
    assign bus_rr.req1_a    = rq[1][1].a;
    assign bus_rr.req1_b    = rq[1][1].b;
    assign bus_rr.req1_op   = rq[1][1].op;
    assign bus_rr.req1_tag  = rq[1][1].tag;
    assign bus_rr.rsp_ready = rsp_rdy[1];
    assign ready[1] = bus_rr.req_ready;
    assign rsp[1]   = {bus_rr.rsp_valid, bus_rr.rsp_data, bus_rr.rsp_zero,
                       bus_rr.rsp_err, bus_rr.rsp_id, bus_rr.rsp_tag};

    assign alu_c[0]    = alu_fn(alu_a[0], alu_b[0], alu_op[0]);
    assign alu_c[1]    = alu_fn(alu_a[1], alu_b[1], alu_op[1]);
    assign alu_zero[0] = {7'b1010101, alu_c[0] == '0};
    assign alu_zero[1] = {7'b1010101, alu_c[1] == '0};

    alu_arbiter #(.DW(DW), .OPW(OPW), .TAGW(TAGW), .RR(0)) dut_fp (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus_fp),
        .alu_a    (alu_a[0]),
        .alu_b    (alu_b[0]),
        .alu_op   (alu_op[0]),
        .alu_c    (alu_c[0]),
        .alu_zero (alu_zero[0])
    );

    alu_arbiter #(.DW(DW), .OPW(OPW), .TAGW(TAGW), .RR(1)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus_rr),
        .alu_a    (alu_a[1]),
        .alu_b    (alu_b[1]),
        .alu_op   (alu_op[1]),
        .alu_c    (alu_c[1]),
        .alu_zero (alu_zero[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // requester rule: a request left waiting must present the same operands next cycle
    req_t snap[2][2];
    bit   held[2][2];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                if (held[d][p] && valid[d][p])
                    chk("hold_stable", 64'(rq[d][p] == snap[d][p]), 64'd1);
                held[d][p] = rstn && valid[d][p] && !ready[d][p];
                snap[d][p] = rq[d][p];
            end
    end

    task automatic txn(input int d, input int p, input req_t r);
        rsp_t       e;
        logic [1:0] pv;
        e  = model(r, p[0]);
        pv = (p == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        rq[d][p]   = r;
        valid[d]   = pv;
        rsp_rdy[d] = 1'b1;
        #1;
        chk("accept", 64'(ready[d]), 64'(pv));
        if (d == 1) mptr[1] = (p == 0);
        @(negedge clk);
        valid[d] = 2'b00;
        #1;
        chk("exec_op", 64'(alu_op[d]), e.err ? 64'd0 : 64'(r.op));
        chk("exec_a", 64'(alu_a[d]), 64'(r.a));
        chk("exec_b", 64'(alu_b[d]), 64'(r.b));
        chk("exec_ready", 64'(ready[d]), 64'd0);
        chk("exec_rsp_valid", 64'(rsp[d].vld), 64'd0);
        @(negedge clk);
        #1;
        chk("rsp", 64'(rsp[d]), 64'(e));
        chk("rsp_op_nop", 64'(alu_op[d]), 64'd0);
        @(negedge clk);
        #1;
        chk("rsp_done", 64'(rsp[d].vld), 64'd0);
    endtask

    task automatic stream(input int d, input int n, input bit rnd,
                          output logic [15:0] order, output int ng);
        req_t           q[2][$];
        rsp_t           e_rsp;
        logic [OPW-1:0] e_op;
        logic [1:0]     eg;
        bit             busy;
        int             since;
        int             cyc;
        int             pg;
        order = '0; ng = 0; busy = 0; since = 0; cyc = 0; e_rsp = '0; e_op = '0;
        for (int i = 0; i < n; i++) begin
            q[0].push_back(rand_req());
            q[1].push_back(rand_req());
        end
        while ((q[0].size() != 0 || q[1].size() != 0 || busy) && cyc < 40 * n + 20) begin
            @(negedge clk);
            cyc++;
            if (busy) since++;
            for (int p = 0; p < 2; p++) begin
                valid[d][p] = (q[p].size() != 0) && (!rnd || $urandom_range(0, 3) != 0);
                if (q[p].size() != 0) rq[d][p] = q[p][0];
            end
            rsp_rdy[d] = !rnd || ($urandom_range(0, 2) != 0);
            #1;
            if (busy)                 eg = 2'b00;
            else if (valid[d] == 2'b11) eg = (d == 1 && mptr[d]) ? 2'b10 : 2'b01;
            else                      eg = valid[d];
            chk("grant", 64'(ready[d]), 64'(eg));
            chk("rsp_valid", 64'(rsp[d].vld), 64'(busy && since >= 2));
            if (busy && since == 1) chk("stream_alu_op", 64'(alu_op[d]), 64'(e_op));
            if (busy && since >= 2) chk("stream_rsp", 64'(rsp[d]), 64'(e_rsp));
            if (|(ready[d] & valid[d]) && ng < 16) begin
                order[ng] = ready[d][1];
                ng++;
            end
            if (busy && since >= 2 && rsp_rdy[d]) begin
                busy = 0;
            end else if (eg != 2'b00) begin
                pg    = eg[1] ? 1 : 0;
                e_rsp = model(q[pg][0], eg[1]);
                e_op  = e_rsp.err ? '0 : q[pg][0].op;
                void'(q[pg].pop_front());
                if (d == 1) mptr[1] = (pg == 0);
                busy  = 1;
                since = 0;
            end
        end
        valid[d]   = 2'b00;
        rsp_rdy[d] = 1'b1;
        chk("stream_done", 64'(q[0].size() + q[1].size() + int'(busy)), 64'd0);
    endtask

    initial begin
        logic [15:0] order;
        int          ng;
        rsp_t        e;
        req_t        r;
        for (int d = 0; d < 2; d++) begin
            valid[d] = 2'b00;
            rsp_rdy[d] = 1'b1;
            rq[d][0] = '0;
            rq[d][1] = '0;
            mptr[d] = 0;
            held[d][0] = 0;
            held[d][1] = 0;
        end
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        valid[0] = 2'b11;
        valid[1] = 2'b11;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_rsp", 64'(rsp[d]), 64'd0);
            chk("reset_alu_a", 64'(alu_a[d]), 64'd0);
            chk("reset_alu_b", 64'(alu_b[d]), 64'd0);
            chk("reset_alu_op", 64'(alu_op[d]), 64'd0);
            chk("reset_grant", 64'(ready[d]), 64'h1);
        end
        valid[0] = 2'b00;
        valid[1] = 2'b00;

        // basic add, wrap-around add, illegal op, other ops on both instances
        txn(1, 0, '{32'd5, 32'd7, 5'b00011, 4'hA});
        chk("add_5_7_data", 64'(model('{32'd5, 32'd7, 5'b00011, 4'hA}, 1'b0).data), 64'd12);
        txn(1, 0, '{32'hFFFF_FFFF, 32'd1, 5'b00011, 4'h3});
        txn(1, 1, '{32'h1234_5678, 32'h9, 5'b00111, 4'h6});
        txn(1, 1, '{32'h1000, 32'hABCD_0000, 5'b00001, 4'h1});
        txn(0, 1, '{32'h0000_4000, 32'h0000_0010, 5'b00010, 4'hF});
        txn(0, 0, '{32'h8000_0000, 32'h8000_0000, 5'b00011, 4'h2});

        // response backpressure for five cycles with both ports waiting
        r = '{32'd100, 32'd23, 5'b00011, 4'h9};
        e = model(r, 1'b0);
        @(negedge clk);
        rq[1][0] = r;
        valid[1] = 2'b01;
        rsp_rdy[1] = 1'b0;
        #1;
        chk("bp_accept", 64'(ready[1]), 64'h1);
        mptr[1] = 1;
        @(negedge clk);
        rq[1][0] = '{32'd1, 32'd2, 5'b00011, 4'h4};
        rq[1][1] = '{32'd3, 32'd4, 5'b00010, 4'h5};
        valid[1] = 2'b11;
        #1;
        chk("bp_exec_ready", 64'(ready[1]), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("bp_rsp_stable", 64'(rsp[1]), 64'(e));
            chk("bp_ready_low", 64'(ready[1]), 64'd0);
        end
        @(negedge clk);
        rsp_rdy[1] = 1'b1;
        #1;
        chk("bp_release_rsp", 64'(rsp[1]), 64'(e));
        @(negedge clk);
        #1;
        chk("bp_after_valid", 64'(rsp[1].vld), 64'd0);
        chk("bp_after_grant", 64'(ready[1]), 64'h2);
        valid[1] = 2'b00;

        // reset while in EXEC abandons the request
        @(negedge clk);
        rq[1][0] = '{32'd9, 32'd9, 5'b00011, 4'h7};
        valid[1] = 2'b01;
        #1;
        chk("rst_accept", 64'(ready[1]), 64'h1);
        @(negedge clk);
        valid[1] = 2'b00;
        rstn = 1'b0;
        #1;
        chk("rst_exec_op", 64'(alu_op[1]), 64'd3);
        @(negedge clk);
        #1;
        chk("rst_rsp_valid", 64'(rsp[1].vld), 64'd0);
        chk("rst_alu_op", 64'(alu_op[1]), 64'd0);
        chk("rst_alu_a", 64'(alu_a[1]), 64'd0);
        rstn = 1'b1;
        mptr[0] = 0;
        mptr[1] = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_no_rsp", 64'(rsp[1].vld), 64'd0);
        end

        // both ports valid: alternation vs port-0 priority
        stream(1, 3, 1'b0, order, ng);
        chk("rr_count", 64'(ng), 64'd6);
        chk("rr_order", 64'(order[5:0]), 64'b101010);
        stream(0, 3, 1'b0, order, ng);
        chk("fp_count", 64'(ng), 64'd6);
        chk("fp_order", 64'(order[5:0]), 64'b111000);

        // random traffic with valid drops and response backpressure
        stream(1, 25, 1'b1, order, ng);
        stream(0, 25, 1'b1, order, ng);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
